// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage.
// Serves word fetches from a DEPTH-word array with a fixed LATENCY. While a
// fetch is outstanding the PC and IF/ID registers are stalled. Misaligned or
// out-of-range PCs return NOP immediately with an addr_err pulse.
module imem_responder #(
   parameter int          DEPTH     = 256,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [31:0] NOP       = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic [31:0]              req_addr,
   input  logic                     flush,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [31:0]              load_data,
   output logic [31:0]              inst,
   output logic                     inst_valid,
   output logic                     hold_pc,
   output logic                     hold_if,
   output logic                     addr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY) + 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   logic [31:0]   mem [DEPTH];
   state_t        state;
   logic [CW-1:0] cnt;
   logic [AW-1:0] idx_latched;

   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic          bad;
   logic          unused_offset;

   // Byte offset from the array base; a wrap below ADDR_BASE lands far out of
   // range, so it is caught by the upper-bits test.
   assign offset        = req_addr - ADDR_BASE;
   assign idx           = offset[AW+1:2];
   assign bad           = (req_addr[1:0] != 2'b00) || (offset[31:AW+2] != '0);
   assign unused_offset = &{1'b0, offset[1:0]};

   // Stalls are pure functions of the registered state.
   assign hold_pc = (state == BUSY);
   assign hold_if = (state == BUSY);

   // Loader write port; array contents survive reset. A read on the same edge
   // sees the old word because both sides use non-blocking updates.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   // Fetch FSM: accept in IDLE, count down in BUSY, flush abandons the fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         idx_latched <= '0;
         inst        <= NOP;
         inst_valid  <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         inst_valid <= 1'b0;
         addr_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && !flush) begin
                  if (bad) begin
                     inst       <= NOP;
                     inst_valid <= 1'b1;
                     addr_err   <= 1'b1;
                  end else if (LATENCY == 1) begin
                     inst       <= mem[idx];
                     inst_valid <= 1'b1;
                  end else begin
                     idx_latched <= idx;
                     cnt         <= CW'(LATENCY - 1);
                     state       <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (flush) begin
                  state <= IDLE;
               end else if (cnt == CW'(1)) begin
                  inst       <= mem[idx_latched];
                  inst_valid <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
